mux_n_to_1_stream: RTL and testbench

Parametrised successor to the plain 2:1 select mux. It picks one of N W-bit valid/ready input channels and forwards the chosen beat through a one-deep output register. The channel is chosen either by an explicit select or by round-robin arbitration. It sits between multiple bus masters or peripherals and a single downstream consumer, where a bare combinational mux would lose or duplicate beats.

---
 rtl/mux_n_to_1_stream.sv | 123 ++++++++++++
 tb/tb_mux_n_to_1_stream.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_stream.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_to_1_stream
// Purpose  : N:1 valid/ready stream multiplexer with a one-deep output
//            register. Selects a channel by explicit index (mode = 0) or by
//            round-robin arbitration (mode = 1). It sustains one beat per
//            cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1        system clock, rising edge
//   reset_n    in   1        asynchronous active-low reset
//   mode       in   1        0 = explicit select, 1 = round-robin
//   mux_sel    in   SEL_W    channel index used when mode = 0
//   in_data    in   N*W      packed channel data, channel i at [i*W +: W]
//   in_valid   in   N        per-channel valid
//   in_ready   out  N        per-channel ready (one-hot or zero)
//   out_data   out  W        registered output data
//   out_ch     out  SEL_W    channel that supplied out_data
//   out_valid  out  1        output beat valid
//   out_ready  in   1        downstream ready
// ============================================================================
module mux_n_to_1_stream #(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] mux_sel,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             load;
  logic             transfer;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] last_grant;
  logic [W-1:0]     grant_data;
  logic [31:0]      sel_ext;

  // The register may take a new beat when empty or when its beat leaves now.
  assign load     = !out_valid || out_ready;
  // Zero-extended so out-of-range indices (N not a power of two) never match.
  assign sel_ext  = 32'(mux_sel);
  // reset_n gating keeps every ready low while reset is held.
  assign transfer = load && grant_valid && reset_n;

  // Grant selection. In round-robin mode the search runs from the farthest
  // offset down to the nearest so the nearest valid channel is assigned last
  // and wins, avoiding any early loop exit.
  always_comb begin
    int pos;
    pos         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel_ext == 32'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        pos = int'(last_grant) + k;
        if (pos >= N) begin
          pos = pos - N;
        end
        for (int i = 0; i < N; i++) begin
          if (pos == i && in_valid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = transfer && (grant_idx == SEL_W'(i));
    end
  end

  // Output register. A load during a consume replaces the beat without a
  // bubble; a consume with no load empties the register but keeps the old
  // data and channel visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_W'(N - 1);
    end else if (transfer) begin
      out_valid  <= 1'b1;
      out_data   <= grant_data;
      out_ch     <= grant_idx;
      last_grant <= grant_idx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_n_to_1_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_n_to_1_stream
// Purpose  : Directed self-checking bench for mux_n_to_1_stream. A reference
//            model of the N=4 instance predicts grants and pushes expected
//            beats to a scoreboard that is popped when the output updates.
//            Two further instances (N=2/W=1, N=5/W=16) cover the parameter
//            sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_n_to_1_stream;

  logic clk;
  logic rst_n;

  // N=4, W=8 instance
  logic        mode4, ovalid4, oready4;
  logic [1:0]  sel4, och4;
  logic [31:0] data4;
  logic [3:0]  valid4, ready4;
  logic [7:0]  odata4;

  // N=5, W=16 instance
  logic        mode5, ovalid5, oready5;
  logic [2:0]  sel5, och5;
  logic [79:0] data5;
  logic [4:0]  valid5, ready5;
  logic [15:0] odata5;

  // N=2, W=1 instance
  logic        mode2, ovalid2, oready2;
  logic [0:0]  sel2, och2;
  logic [1:0]  data2, valid2, ready2;
  logic [0:0]  odata2;

  int tests = 0;
  int fails = 0;

  // Reference model state for the N=4 instance
  bit         m_valid;
  int         m_last;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  logic [9:0] sb[$];   // {ch, data}

  mux_n_to_1_stream #(.N(4), .W(8)) dut4 (
    .clk(clk), .reset_n(rst_n), .mode(mode4), .mux_sel(sel4),
    .in_data(data4), .in_valid(valid4), .in_ready(ready4),
    .out_data(odata4), .out_ch(och4), .out_valid(ovalid4), .out_ready(oready4)
  );

  mux_n_to_1_stream #(.N(5), .W(16)) dut5 (
    .clk(clk), .reset_n(rst_n), .mode(mode5), .mux_sel(sel5),
    .in_data(data5), .in_valid(valid5), .in_ready(ready5),
    .out_data(odata5), .out_ch(och5), .out_valid(ovalid5), .out_ready(oready5)
  );

  mux_n_to_1_stream #(.N(2), .W(1)) dut2 (
    .clk(clk), .reset_n(rst_n), .mode(mode2), .mux_sel(sel2),
    .in_data(data2), .in_valid(valid2), .in_ready(ready2),
    .out_data(odata2), .out_ch(och2), .out_valid(ovalid2), .out_ready(oready2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = 3;
    m_data  = 8'h00;
    m_ch    = 2'd0;
    sb.delete();
  endtask

  // One clock cycle on the N=4 instance. Inputs are already driven; the
  // model predicts the grant, checks in_ready, then checks the output after
  // the edge.
  task automatic cyc(input string tag);
    bit         gv;
    bit         tr;
    int         gi;
    int         c;
    logic [3:0] er;
    logic [9:0] b;
    #1;
    gv = 1'b0;
    gi = 0;
    if (!mode4) begin
      if (valid4[sel4]) begin
        gv = 1'b1;
        gi = int'(sel4);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!gv && valid4[2'(c)]) begin
          gv = 1'b1;
          gi = c;
        end
      end
    end
    tr = (!m_valid || oready4) && gv;
    er = tr ? 4'(1 << gi) : 4'b0000;
    chk({tag, ":in_ready"}, 32'(ready4), 32'(er));
    if (tr) begin
      sb.push_back({2'(gi), 8'(data4 >> (gi * 8))});
      m_valid = 1'b1;
      m_last  = gi;
    end else if (oready4) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, ":out_valid"}, 32'(ovalid4), 32'(m_valid));
    if (tr) begin
      b      = sb.pop_front();
      m_ch   = b[9:8];
      m_data = b[7:0];
    end
    chk({tag, ":out_ch"}, 32'(och4), 32'(m_ch));
    chk({tag, ":out_data"}, 32'(odata4), 32'(m_data));
  endtask

  initial begin
    rst_n  = 1'b0;
    mode4  = 1'b0; sel4 = '0; data4 = '0; valid4 = '0; oready4 = 1'b0;
    mode5  = 1'b0; sel5 = '0; data5 = '0; valid5 = '0; oready5 = 1'b0;
    mode2  = 1'b0; sel2 = '0; data2 = '0; valid2 = '0; oready2 = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst:out_valid", 32'(ovalid4), 32'd0);
    chk("rst:out_data", 32'(odata4), 32'd0);
    chk("rst:out_ch", 32'(och4), 32'd0);
    chk("rst:in_ready", 32'(ready4), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-beat: load 0xA5 from ch2 and stall it
    data4   = {8'h13, 8'hA5, 8'h11, 8'h10};
    mode4   = 1'b0;
    sel4    = 2'd2;
    valid4  = 4'b0100;
    oready4 = 1'b0;
    cyc("midrst_load");
    mode4  = 1'b1;
    valid4 = 4'b1111;
    rst_n  = 1'b0;
    #1;
    chk("midrst:out_valid", 32'(ovalid4), 32'd0);
    chk("midrst:out_data", 32'(odata4), 32'd0);
    chk("midrst:out_ch", 32'(och4), 32'd0);
    chk("midrst:in_ready", 32'(ready4), 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Round-robin fairness: first grant after reset is ch0, then 1,2,3,...
    data4   = {8'h13, 8'h12, 8'h11, 8'h10};
    oready4 = 1'b1;
    for (int i = 0; i < 8; i++) cyc("rr_all");
    chk("rr_all:last_ch", 32'(och4), 32'd3);

    // Sparse round-robin: only ch1 and ch3 valid -> 1,3,1,3
    valid4 = 4'b1010;
    for (int i = 0; i < 4; i++) cyc("rr_sparse");

    // Explicit select of ch1 with all channels valid
    mode4  = 1'b0;
    sel4   = 2'd1;
    valid4 = 4'b1111;
    for (int i = 0; i < 3; i++) cyc("sel1");

    // Selected channel not valid: no grant, output drains after one cycle
    sel4   = 2'd3;
    valid4 = 4'b0111;
    cyc("sel3_idle_a");
    cyc("sel3_idle_b");

    // Backpressure: load 0x22 from ch2, then stall three cycles
    data4   = {8'h33, 8'h22, 8'h11, 8'h10};
    sel4    = 2'd2;
    valid4  = 4'b1111;
    oready4 = 1'b1;
    cyc("bp_load");
    oready4 = 1'b0;
    for (int i = 0; i < 3; i++) cyc("bp_stall");
    chk("bp:held_data", 32'(odata4), 32'h22);
    // Consume 0x22 and load ch3 on the same edge
    oready4 = 1'b1;
    sel4    = 2'd3;
    valid4  = 4'b1000;
    cyc("bp_swap");

    // Mode switch: round-robin up to ch2, explicit ch0, then resume at ch1
    mode4  = 1'b1;
    valid4 = 4'b1111;
    for (int i = 0; i < 3; i++) cyc("ms_rr");
    mode4 = 1'b0;
    sel4  = 2'd0;
    cyc("ms_sel0");
    mode4 = 1'b1;
    cyc("ms_resume");
    chk("ms_resume:ch", 32'(och4), 32'd1);
    valid4 = 4'b0000;

    // N=5, W=16: out-of-range selects never grant
    for (int i = 0; i < 5; i++) data5[i*16 +: 16] = 16'hA000 + 16'(i);
    valid5  = 5'b11111;
    oready5 = 1'b1;
    mode5   = 1'b0;
    for (int s = 5; s <= 7; s++) begin
      sel5 = 3'(s);
      #1;
      chk("n5_oor:in_ready", 32'(ready5), 32'd0);
    end
    sel5 = 3'd4;
    #1;
    chk("n5_sel4:in_ready", 32'(ready5), 32'b10000);
    @(posedge clk);
    #1;
    chk("n5_sel4:out_ch", 32'(och5), 32'd4);
    chk("n5_sel4:out_data", 32'(odata5), 32'hA004);
    // Round-robin wraps from ch4 back to ch0
    mode5 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("n5_rr:out_valid", 32'(ovalid5), 32'd1);
      chk("n5_rr:out_ch", 32'(och5), 32'(c % 5));
      chk("n5_rr:out_data", 32'(odata5), 32'hA000 + 32'(c % 5));
    end
    valid5 = '0;

    // N=2, W=1: round-robin alternates; ch0 carries 1, ch1 carries 0
    data2   = 2'b01;
    valid2  = 2'b11;
    mode2   = 1'b1;
    oready2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("n2_rr:out_ch", 32'(och2), 32'(c % 2));
      chk("n2_rr:out_data", 32'(odata2), (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    valid2 = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
